load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 136 +++++++++++++
 tb/tb_load_store_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns one core access into a single request on a simple ack-based bus.
// Latency: 3 cycles minimum (IDLE accept, BUS, RESP). Illegal accesses take 2 cycles.
// Backpressure: busy_o stalls the core until RESP; bus_req_o is held until ack or timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  mask_i,
    input  logic        sext_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  tmo_cnt;
    logic [1:0]  off_q;
    logic [3:0]  mask_q;
    logic        sext_q;

    logic        legal;
    logic [3:0]  sel;
    logic [31:0] rep_wdata;
    logic [31:0] shifted;
    logic [31:0] load_data;

    assign busy_o = (state != IDLE);

    always_comb begin
        legal     = 1'b0;
        sel       = mask_i << addr_i[1:0];
        rep_wdata = wdata_i;
        case (mask_i)
            4'b0001: begin
                legal     = 1'b1;
                rep_wdata = {4{wdata_i[7:0]}};
            end
            4'b0011: begin
                legal     = ~addr_i[0];
                rep_wdata = {2{wdata_i[15:0]}};
            end
            4'b1111: legal = (addr_i[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    // Load lanes are shifted down to bit 0, then truncated and extended per access size.
    always_comb begin
        shifted   = bus_rdata_i >> {off_q, 3'b000};
        load_data = shifted;
        case (mask_q)
            4'b0001: load_data = {{24{sext_q & shifted[7]}}, shifted[7:0]};
            4'b0011: load_data = {{16{sext_q & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= IDLE;
            tmo_cnt     <= 8'd0;
            off_q       <= 2'd0;
            mask_q      <= 4'd0;
            sext_q      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            rdata_o     <= 32'd0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'd0;
            bus_sel_o   <= 4'd0;
            bus_wdata_o <= 32'd0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        if (legal) begin
                            state       <= BUS;
                            tmo_cnt     <= 8'd0;
                            off_q       <= addr_i[1:0];
                            mask_q      <= mask_i;
                            sext_q      <= sext_i;
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= we_i;
                            bus_addr_o  <= {addr_i[31:2], 2'b00};
                            bus_sel_o   <= sel;
                            bus_wdata_o <= rep_wdata;
                        end else begin
                            state   <= RESP;
                            err_o   <= 1'b1;
                            rdata_o <= 32'd0;
                        end
                    end
                end
                BUS: begin
                    // Ack is checked first so an ack on the final allowed cycle still completes.
                    if (bus_ack_i) begin
                        state     <= RESP;
                        bus_req_o <= 1'b0;
                        done_o    <= 1'b1;
                        rdata_o   <= bus_we_o ? 32'd0 : load_data;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state     <= RESP;
                        bus_req_o <= 1'b0;
                        err_o     <= 1'b1;
                        rdata_o   <= 32'd0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios followed by random accesses against a reference model.
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [3:0]  mask_i = '0;
    logic        sext_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic        busy_o, done_o, err_o;
    logic [31:0] rdata_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rdata = '0;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .mask_i(mask_i), .sext_i(sext_i), .wdata_i(wdata_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [3:0] m);
        case (m)
            4'b0001: return 1;
            4'b0011: return 2;
            4'b1111: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                               input int sz, input logic sx);
        longint unsigned keep, v;
        keep = (64'd1 << (8 * sz)) - 64'd1;
        v    = (64'(rd) >> (8 * (a % 4))) & keep;
        if (sx && (((v >> (8 * sz - 1)) & 64'd1) == 64'd1))
            v = v | ~keep;
        return v[31:0];
    endfunction

    // One complete access; ack_at is the BUS cycle (0-based) carrying the ack, <0 or >=TMO means never.
    task automatic run_access(input logic we, input logic [31:0] a, input logic [3:0] m,
                              input logic sx, input logic [31:0] wd, input logic [31:0] rd,
                              input int ack_at, input bit hold, input bit stray);
        int          sz;
        bit          ok, acked;
        logic [31:0] exp_wd, exp_rd;
        logic [3:0]  exp_sel;
        sz      = size_of(m);
        ok      = (sz != 0) && ((a % sz) == 0);
        acked   = (ack_at >= 0) && (ack_at < TMO);
        exp_sel = 4'(((1 << sz) - 1) << (a % 4));
        exp_wd  = (sz == 1) ? wd[7:0] * 32'h0101_0101 :
                  (sz == 2) ? wd[15:0] * 32'h0001_0001 : wd;

        req_i = 1'b1; we_i = we; addr_i = a; mask_i = m; sext_i = sx; wdata_i = wd;
        bus_ack_i = stray;
        tick();
        if (!hold) req_i = 1'b0;
        else addr_i = $urandom;

        if (!ok) begin
            chk("ill_busy", 32'(busy_o), 32'd1);
            chk("ill_err", 32'(err_o), 32'd1);
            chk("ill_done", 32'(done_o), 32'd0);
            chk("ill_bus_req", 32'(bus_req_o), 32'd0);
            chk("ill_rdata", rdata_o, 32'd0);
            last_rdata = 32'd0;
        end else begin
            for (int k = 0; k < TMO; k++) begin
                chk("bus_busy", 32'(busy_o), 32'd1);
                chk("bus_req", 32'(bus_req_o), 32'd1);
                chk("bus_we", 32'(bus_we_o), 32'(we));
                chk("bus_addr", bus_addr_o, a & 32'hFFFF_FFFC);
                chk("bus_sel", 32'(bus_sel_o), 32'(exp_sel));
                chk("bus_wdata", bus_wdata_o, exp_wd);
                chk("bus_done", 32'(done_o), 32'd0);
                chk("bus_err", 32'(err_o), 32'd0);
                chk("bus_rdata_hold", rdata_o, last_rdata);
                bus_ack_i   = (k == ack_at);
                bus_rdata_i = (k == ack_at) ? rd : $urandom;
                tick();
                if (k == ack_at) break;
            end
            exp_rd = (acked && !we) ? model_load(rd, a, sz, sx) : 32'd0;
            chk("resp_busy", 32'(busy_o), 32'd1);
            chk("resp_bus_req", 32'(bus_req_o), 32'd0);
            chk("resp_done", 32'(done_o), 32'(acked));
            chk("resp_err", 32'(err_o), 32'(!acked));
            chk("resp_rdata", rdata_o, exp_rd);
            last_rdata = exp_rd;
        end
        // A stray ack in RESP must not produce anything.
        bus_ack_i = stray;
        req_i = 1'b0;
        tick();
        bus_ack_i = 1'b0;
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_done", 32'(done_o), 32'd0);
        chk("idle_err", 32'(err_o), 32'd0);
        chk("idle_rdata", rdata_o, last_rdata);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_bus_req", 32'(bus_req_o), 32'd0);
        chk("rst_bus_we", 32'(bus_we_o), 32'd0);
        chk("rst_bus_addr", bus_addr_o, 32'd0);
        chk("rst_bus_sel", 32'(bus_sel_o), 32'd0);
        chk("rst_bus_wdata", bus_wdata_o, 32'd0);
        reset_i = 1'b0;
        tick();

        // Byte load, sign-extended, ack in the first BUS cycle.
        run_access(1'b0, 32'h1003, 4'b0001, 1'b1, 32'h0, 32'h80FF_FF00, 0, 1'b0, 1'b0);
        chk("byte_load_value", last_rdata, 32'hFFFF_FF80);
        // Half store, lane-replicated data, ack after two cycles.
        run_access(1'b1, 32'h2002, 4'b0011, 1'b0, 32'h1234_ABCD, 32'hDEAD_BEEF, 2, 1'b0, 1'b0);
        // Misaligned word and an illegal mask encoding.
        run_access(1'b0, 32'h3001, 4'b1111, 1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
        run_access(1'b0, 32'h3000, 4'b0101, 1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b1);
        // Timeout with no ack, then ack on the very last allowed cycle.
        run_access(1'b0, 32'h3100, 4'b1111, 1'b0, 32'h0, 32'h1111_2222, -1, 1'b0, 1'b0);
        run_access(1'b0, 32'h3104, 4'b1111, 1'b0, 32'h0, 32'h5555_6666, TMO - 1, 1'b0, 1'b0);
        // Halfword zero-extend with req_i held through the access.
        run_access(1'b0, 32'h4002, 4'b0011, 1'b0, 32'h0, 32'h9ABC_0000, 1, 1'b1, 1'b0);
        chk("half_load_value", last_rdata, 32'h0000_9ABC);

        // Reset in the second BUS cycle, late ack alongside a fresh request.
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h5000; mask_i = 4'b1111; wdata_i = 32'hCAFE_F00D;
        tick();
        req_i = 1'b0;
        tick();
        chk("pre_rst_bus_req", 32'(bus_req_o), 32'd1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_bus_req", 32'(bus_req_o), 32'd0);
        chk("mid_rst_bus_we", 32'(bus_we_o), 32'd0);
        chk("mid_rst_bus_addr", bus_addr_o, 32'd0);
        chk("mid_rst_bus_sel", 32'(bus_sel_o), 32'd0);
        chk("mid_rst_bus_wdata", bus_wdata_o, 32'd0);
        chk("mid_rst_done", 32'(done_o), 32'd0);
        chk("mid_rst_err", 32'(err_o), 32'd0);
        chk("mid_rst_rdata", rdata_o, 32'd0);
        last_rdata = 32'd0;
        run_access(1'b0, 32'h6001, 4'b0001, 1'b0, 32'h0, 32'h0000_A500, 0, 1'b0, 1'b1);

        for (int i = 0; i < 80; i++) begin
            logic [3:0]  m;
            logic [31:0] a;
            int          pick;
            pick = $urandom_range(0, 9);
            m = (pick < 3) ? 4'b0001 : (pick < 6) ? 4'b0011 : (pick < 9) ? 4'b1111 : 4'($urandom);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (m == 4'b0011) a[0] = 1'b0;
                if (m == 4'b1111) a[1:0] = 2'b00;
            end
            run_access(1'($urandom), a, m, 1'($urandom), $urandom, $urandom,
                       $urandom_range(0, TMO + 1), 1'($urandom_range(0, 3) == 0),
                       1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
